pls_reg_bank_slave: RTL and testbench
=====================================

Name: pls_reg_bank_slave

Overview:
- Responder end of the IModBus register-write bus; the configurator FSM is the master.
- Accepts address/data write beats into a shadow register bank and holds off the master with s_wready.
- On a commit request, copies the shadow bank atomically into the active bank, which the pulse generator reads through a registered read port.
- One instance per register group (reg0/reg1). Commit is driven from the group-select toggle.

Parameters:
- DATA_SIZE, 32, width of wdata, register contents and rdata.
- ADDR_W, 8, width of waddr and raddr.
- DEPTH, 38, number of implemented registers (addresses 0..DEPTH-1).
- HOLD_CYCLES, 1, cycles s_wready stays low after each accepted write (range 0..15).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_waddr  in  ADDR_W  write address.
- s_wdata  in  DATA_SIZE  write data.
- s_awvalid  in  1  address valid.
- s_dwvalid  in  1  data valid.
- s_wready  out  1  slave can accept a beat.
- commit  in  1  single-cycle request: shadow -> active.
- raddr  in  ADDR_W  active-bank read address.
- rdata  out  DATA_SIZE  active-bank data, registered.
- wr_count  out  ADDR_W  accepted in-range writes since last commit, saturating.
- commit_done  out  1  one-cycle pulse when the copy is done.
- addr_err  out  1  sticky: a write to address >= DEPTH occurred.

Behaviour:
- Reset is asynchronous, active-low, one clock.
- Reset values: all shadow and active registers 0; s_wready=0; rdata=0; wr_count=0; commit_done=0; addr_err=0; state=INIT.
- Accept condition: s_awvalid & s_dwvalid & s_wready at a rising edge. awvalid without dwvalid, or the reverse, is ignored and writes nothing.
- Accepted beat, in range: shadow[s_waddr] <= s_wdata on that edge; wr_count increments, saturating at all-ones.
- Accepted beat, out of range (s_waddr >= DEPTH): no write, wr_count unchanged, addr_err <= 1. addr_err clears only on reset.
- FSM states:
  - INIT: s_wready=0; goes to READY on the next cycle. A commit sampled here is latched as pending.
  - READY: s_wready=1.
    - Accept with HOLD_CYCLES>0 -> HOLD, counter loaded with HOLD_CYCLES.
    - Accept with HOLD_CYCLES=0 -> stay in READY.
    - commit or pending commit with no accept -> COMMIT.
  - HOLD: s_wready=0; counter decrements. At counter==1 -> COMMIT if commit is pending, else READY.
  - COMMIT: s_wready=0.
    - active[i] <= shadow[i] for all i in one edge.
    - wr_count <= 0; pending cleared; commit_done=1 for exactly this cycle.
    - Then -> READY.
- Simultaneous accept and commit in READY: the write lands in shadow first. The commit becomes pending and executes after HOLD (or next cycle if HOLD_CYCLES=0), so the committed image includes that write.
- commit asserted in HOLD or COMMIT: latched as pending, executed once. Multiple requests before execution collapse into one.
- Shadow writes are never visible in rdata until commit.
- Read port: rdata <= active[raddr] every cycle, latency 1. raddr >= DEPTH returns 0.
- Mid-operation reset: all state returns to reset values immediately. Any pending commit is discarded.

Test Plan:
- Reset release: s_wready 0 for one cycle, then 1. rdata=0 for raddr=0..37. wr_count=0.
- Write 0xDEADBEEF to addr 5 with HOLD_CYCLES=1:
  - s_wready low for exactly one cycle after accept; wr_count=1.
  - raddr=5 still reads 0.
  - Pulse commit: commit_done after 1 cycle; raddr=5 reads 0xDEADBEEF; wr_count=0.
- Write to addr 38 (DEPTH=38): addr_err=1 and stays 1; wr_count unchanged; no register altered after commit.
- Accept to addr 2 (0x11) and commit in the same cycle: commit_done occurs after HOLD; raddr=2 reads 0x11.
- Master toggling awvalid/dwvalid each cycle, 20 writes to addresses 0..19 with data=addr*3: all captured. Each beat accepted only when s_wready=1. After commit, active[i]=3*i.
- Assert aresetn low during HOLD with commit pending: no commit_done ever appears. All outputs at reset values; active bank reads 0.

Source files
------------

// File: rtl/pls_reg_bank_slave.sv
// Responder end of the register-write bus: shadow bank filled by write beats, copied
// atomically into the active bank on commit; active bank read through a registered port.
module pls_reg_bank_slave #(
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH       = 38,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [ADDR_W-1:0]    s_waddr,
    input  logic [DATA_SIZE-1:0] s_wdata,
    input  logic                 s_awvalid,
    input  logic                 s_dwvalid,
    output logic                 s_wready,
    input  logic                 commit,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [DATA_SIZE-1:0] rdata,
    output logic [ADDR_W-1:0]    wr_count,
    output logic                 commit_done,
    output logic                 addr_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_READY  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      HOLD_LOAD = 4'(HOLD_CYCLES);

    logic [1:0]           state_q, state_d;
    logic [3:0]           hold_cnt_q, hold_cnt_d;
    logic                 pending_q, pending_d;
    logic [DATA_SIZE-1:0] shadow_q [DEPTH];
    logic [DATA_SIZE-1:0] shadow_d [DEPTH];
    logic [DATA_SIZE-1:0] active_q [DEPTH];
    logic [DATA_SIZE-1:0] active_d [DEPTH];
    logic [DATA_SIZE-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0]    wr_count_q, wr_count_d;
    logic                 addr_err_q, addr_err_d;

    logic             accept;
    logic             waddr_ok;
    logic             raddr_ok;
    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] ridx;

    assign s_wready    = (state_q == ST_READY);
    assign commit_done = (state_q == ST_COMMIT);
    assign rdata       = rdata_q;
    assign wr_count    = wr_count_q;
    assign addr_err    = addr_err_q;

    assign accept   = s_awvalid & s_dwvalid & s_wready;
    assign waddr_ok = ({1'b0, s_waddr} < DEPTH_EXT);
    assign raddr_ok = ({1'b0, raddr} < DEPTH_EXT);
    assign widx     = s_waddr[IDX_W-1:0];
    assign ridx     = raddr[IDX_W-1:0];

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pending_d  = pending_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_READY;
                if (commit) pending_d = 1'b1;
            end
            ST_READY: begin
                if (accept) begin
                    // A commit racing a write is deferred so the write lands in the image.
                    if (commit) pending_d = 1'b1;
                    if (HOLD_CYCLES != 0) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end else if (commit || pending_q) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_HOLD: begin
                if (commit) pending_d = 1'b1;
                if (hold_cnt_q <= 4'd1) begin
                    hold_cnt_d = 4'd0;
                    state_d    = (pending_q || commit) ? ST_COMMIT : ST_READY;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            ST_COMMIT: begin
                pending_d = commit;
                state_d   = ST_READY;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        shadow_d   = shadow_q;
        active_d   = active_q;
        wr_count_d = wr_count_q;
        addr_err_d = addr_err_q;
        if (accept) begin
            if (waddr_ok) begin
                shadow_d[widx] = s_wdata;
                if (wr_count_q != '1) wr_count_d = wr_count_q + ADDR_W'(1);
            end else begin
                addr_err_d = 1'b1;
            end
        end
        if (state_q == ST_COMMIT) begin
            active_d   = shadow_q;
            wr_count_d = '0;
        end
        rdata_d = raddr_ok ? active_q[ridx] : '0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_INIT;
            hold_cnt_q <= 4'd0;
            pending_q  <= 1'b0;
            rdata_q    <= '0;
            wr_count_q <= '0;
            addr_err_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            pending_q  <= pending_d;
            rdata_q    <= rdata_d;
            wr_count_q <= wr_count_d;
            addr_err_q <= addr_err_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
        end
    end

endmodule

// File: tb/tb_pls_reg_bank_slave.sv
// Bench for pls_reg_bank_slave: directed writes/commits; read responses checked through a
// scoreboard queue drained by a negedge monitor.
module tb_pls_reg_bank_slave;

    localparam int DEPTH = 38;

    logic        clk = 1'b0;
    logic        aresetn = 1'b1;
    logic [7:0]  s_waddr = '0;
    logic [31:0] s_wdata = '0;
    logic        s_awvalid = 1'b0;
    logic        s_dwvalid = 1'b0;
    logic        s_wready;
    logic        commit = 1'b0;
    logic [7:0]  raddr = '0;
    logic [31:0] rdata;
    logic [7:0]  wr_count;
    logic        commit_done;
    logic        addr_err;

    always #5 clk = ~clk;

    pls_reg_bank_slave #(
        .DATA_SIZE  (32),
        .ADDR_W     (8),
        .DEPTH      (DEPTH),
        .HOLD_CYCLES(1)
    ) dut (
        .aclk       (clk),
        .aresetn    (aresetn),
        .s_waddr    (s_waddr),
        .s_wdata    (s_wdata),
        .s_awvalid  (s_awvalid),
        .s_dwvalid  (s_dwvalid),
        .s_wready   (s_wready),
        .commit     (commit),
        .raddr      (raddr),
        .rdata      (rdata),
        .wr_count   (wr_count),
        .commit_done(commit_done),
        .addr_err   (addr_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] exp_q [$];
    string       nm_q  [$];
    logic        rd_req = 1'b0;
    logic        rd_pend;

    logic [31:0] shadow_m [DEPTH];
    logic [31:0] active_m [DEPTH];
    int          wc_m;
    int          idx, cyc, hold_m;
    logic        aw, dw, exp_ready, acc, seen_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) rd_pend <= 1'b0;
        else          rd_pend <= rd_req;
    end

    // Monitor: one expected value per read issued the previous cycle.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_unexpected: got %h expected none", rdata);
            end else begin
                chk(nm_q.pop_front(), rdata, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a, input logic [31:0] e, input string name);
        raddr  = 8'(a);
        rd_req = 1'b1;
        exp_q.push_back(e);
        nm_q.push_back(name);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic drain();
        tick();
        tick();
    endtask

    task automatic rd_all(input string tag);
        for (int i = 0; i < DEPTH + 2; i++)
            rd(i, (i < DEPTH) ? active_m[i] : 32'h0, $sformatf("%s_rd%0d", tag, i));
        drain();
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic with_commit);
        int budget = 0;
        s_waddr   = 8'(a);
        s_wdata   = d;
        s_awvalid = 1'b1;
        s_dwvalid = 1'b1;
        commit    = with_commit;
        while (!s_wready && budget < 20) begin
            tick();
            budget++;
        end
        chk("wr_ready_wait", {31'b0, s_wready}, 32'd1);
        tick();
        s_awvalid = 1'b0;
        s_dwvalid = 1'b0;
        commit    = 1'b0;
        if (a < DEPTH) begin
            shadow_m[a] = d;
            wc_m++;
        end
    endtask

    task automatic apply_commit_model();
        for (int i = 0; i < DEPTH; i++) active_m[i] = shadow_m[i];
        wc_m = 0;
    endtask

    task automatic do_commit(input string tag);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk({tag, "_done"}, {31'b0, commit_done}, 32'd1);
        apply_commit_model();
        tick();
        chk({tag, "_done_clr"}, {31'b0, commit_done}, 32'd0);
        chk({tag, "_wrcnt"}, {24'b0, wr_count}, 32'(wc_m));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            shadow_m[i] = '0;
            active_m[i] = '0;
        end
        wc_m = 0;

        // Reset and release
        #1 aresetn = 1'b0;
        tick();
        tick();
        chk("rst_wready", {31'b0, s_wready}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_wrcnt", {24'b0, wr_count}, 32'd0);
        chk("rst_done", {31'b0, commit_done}, 32'd0);
        chk("rst_adderr", {31'b0, addr_err}, 32'd0);
        aresetn = 1'b1;
        #1;
        chk("init_wready", {31'b0, s_wready}, 32'd0);
        tick();
        chk("ready_wready", {31'b0, s_wready}, 32'd1);
        rd_all("reset");

        // Single write, hidden until commit
        wr(5, 32'hDEADBEEF, 1'b0);
        chk("hold_wready", {31'b0, s_wready}, 32'd0);
        chk("wr1_wrcnt", {24'b0, wr_count}, 32'd1);
        tick();
        chk("hold_release", {31'b0, s_wready}, 32'd1);
        rd(5, 32'h0, "shadow_hidden");
        drain();
        do_commit("c1");
        rd(5, 32'hDEADBEEF, "commit5");
        drain();

        // Out-of-range write
        wr(38, 32'h55555555, 1'b0);
        chk("oor_adderr", {31'b0, addr_err}, 32'd1);
        chk("oor_wrcnt", {24'b0, wr_count}, 32'd0);
        tick();
        tick();
        chk("oor_sticky", {31'b0, addr_err}, 32'd1);
        do_commit("c2");
        rd_all("oor");

        // Accept and commit on the same edge
        wr(2, 32'h11, 1'b1);
        chk("ac_hold_nodone", {31'b0, commit_done}, 32'd0);
        tick();
        chk("ac_done", {31'b0, commit_done}, 32'd1);
        apply_commit_model();
        tick();
        chk("ac_done_clr", {31'b0, commit_done}, 32'd0);
        chk("ac_wrcnt", {24'b0, wr_count}, 32'd0);
        rd(2, 32'h11, "ac_rd2");
        drain();

        // Toggling valids, 20 writes
        idx = 0;
        cyc = 0;
        hold_m = 0;
        while (idx < 20 && cyc < 400) begin
            aw = (cyc % 2 == 0);
            dw = (cyc % 3 != 2);
            s_awvalid = aw;
            s_dwvalid = dw;
            s_waddr   = 8'(idx);
            s_wdata   = 32'(idx * 3);
            exp_ready = (hold_m == 0);
            chk($sformatf("tog_ready_c%0d", cyc), {31'b0, s_wready}, {31'b0, exp_ready});
            acc = aw & dw & exp_ready;
            tick();
            if (acc) begin
                shadow_m[idx] = 32'(idx * 3);
                idx++;
                wc_m++;
                hold_m = 1;
            end else begin
                hold_m = 0;
            end
            cyc++;
        end
        s_awvalid = 1'b0;
        s_dwvalid = 1'b0;
        chk("tog_wrcnt", {24'b0, wr_count}, 32'(wc_m));
        tick();
        do_commit("c3");
        rd_all("toggle");

        // Reset while holding with a pending commit
        wr(7, 32'h77, 1'b1);
        aresetn = 1'b0;
        #1;
        chk("mr_wready", {31'b0, s_wready}, 32'd0);
        chk("mr_wrcnt", {24'b0, wr_count}, 32'd0);
        chk("mr_adderr", {31'b0, addr_err}, 32'd0);
        chk("mr_done", {31'b0, commit_done}, 32'd0);
        chk("mr_rdata", rdata, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            shadow_m[i] = '0;
            active_m[i] = '0;
        end
        wc_m = 0;
        seen_done = 1'b0;
        tick();
        seen_done |= commit_done;
        tick();
        seen_done |= commit_done;
        aresetn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #2 seen_done |= commit_done;
            tick();
        end
        chk("mr_no_commit", {31'b0, seen_done}, 32'd0);
        chk("mr_ready", {31'b0, s_wready}, 32'd1);
        rd_all("post_reset");

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
